// File: rtl/jtframe_pocket_upload.sv
// APF bridge read path: fetches four bytes over the ioctl read port and packs them into a 32-bit word.
// Define JTFRAME_POCKET_UPLOAD_BSWAP_EN for big-endian packing (byte 0 in rd_data[31:24]).
module jtframe_pocket_upload #(
  parameter int DIN_LAT = 2,
  parameter int AW      = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic [31:0]   addr,
  input  logic          slot_done,
  output logic [31:0]   rd_data,
  output logic          rd_done,
  output logic          busy,
  output logic          overrun,
  output logic [AW-1:0] ioctl_addr,
  output logic          ioctl_rd,
  input  logic [7:0]    ioctl_din,
  output logic          uploading
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [2:0] LAT   = 3'(DIN_LAT);

  logic [1:0]  st;
  logic [1:0]  k;
  logic [2:0]  cnt;
  logic [31:0] word;
  logic [31:0] word_nxt;
  logic [1:0]  lane;
  logic        slot_pend;
  logic        unused_addr;

  assign unused_addr = ^addr[31:AW-2];
  assign busy        = (st != IDLE);

`ifdef JTFRAME_POCKET_UPLOAD_BSWAP_EN
  assign lane = 2'd3 - k;
`else
  assign lane = k;
`endif

  // Word with the byte arriving this cycle merged in; rd_data takes it directly on the last byte.
  always_comb begin
    word_nxt = word;
    word_nxt[{lane, 3'b000} +: 8] = ioctl_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      k          <= 2'd0;
      cnt        <= 3'd0;
      word       <= 32'd0;
      rd_data    <= 32'd0;
      rd_done    <= 1'b0;
      overrun    <= 1'b0;
      ioctl_addr <= '0;
      ioctl_rd   <= 1'b0;
      uploading  <= 1'b0;
      slot_pend  <= 1'b0;
    end else begin
      rd_done  <= 1'b0;
      ioctl_rd <= 1'b0;
      if (rd && st != IDLE) overrun <= 1'b1;
      case (st)
        IDLE: begin
          if (rd) begin
            ioctl_addr <= {addr[AW-3:0], 2'b00};
            ioctl_rd   <= 1'b1;
            k          <= 2'd0;
            cnt        <= 3'd0;
            uploading  <= 1'b1;
            slot_pend  <= slot_done;
            st         <= FETCH;
          end else if (slot_done) begin
            uploading <= 1'b0;
          end
        end
        FETCH: begin
          if (slot_done) slot_pend <= 1'b1;
          if (cnt == LAT) begin
            word <= word_nxt;
            if (k == 2'd3) begin
              rd_data <= word_nxt;
              rd_done <= 1'b1;
              st      <= DONE;
            end else begin
              k          <= k + 2'd1;
              cnt        <= 3'd0;
              ioctl_addr <= ioctl_addr + AW'(1);
              ioctl_rd   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          // A slot_done seen during the word takes effect only once the word is out.
          if (slot_pend || slot_done) uploading <= 1'b0;
          slot_pend <= 1'b0;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Bench for jtframe_pocket_upload: three instances (DIN_LAT 2, 1, 7) fed by a latency-accurate core memory model.
module tb_jtframe_pocket_upload;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_v       [3];
  logic [31:0] addr_v     [3];
  logic        slot_v     [3];
  logic [31:0] rd_data_v  [3];
  logic        rd_done_v  [3];
  logic        busy_v     [3];
  logic        overrun_v  [3];
  logic [24:0] ioctl_addr_v [3];
  logic        ioctl_rd_v [3];
  logic [7:0]  din_v      [3];
  logic        upl_v      [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mem_mode = 1'b0;

  logic [33:0] exp_q[$];
  int          t_q[$];
  logic [26:0] addr_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jtframe_pocket_upload #(
      .DIN_LAT(g == 0 ? 2 : (g == 1 ? 1 : 7)),
      .AW     (25)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rd        (rd_v[g]),
      .addr      (addr_v[g]),
      .slot_done (slot_v[g]),
      .rd_data   (rd_data_v[g]),
      .rd_done   (rd_done_v[g]),
      .busy      (busy_v[g]),
      .overrun   (overrun_v[g]),
      .ioctl_addr(ioctl_addr_v[g]),
      .ioctl_rd  (ioctl_rd_v[g]),
      .ioctl_din (din_v[g]),
      .uploading (upl_v[g])
    );
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  function automatic logic [7:0] mem_byte(logic [24:0] a, bit m);
    logic [7:0] h;
    h = (a[7:0] ^ a[15:8] ^ {1'b0, a[24:18]}) + 8'h5a;
    return m ? h : a[7:0];
  endfunction

  function automatic logic [24:0] byte_addr(logic [31:0] a, int k);
    longint v;
    v = (longint'(a) * 4 + longint'(k)) % (longint'(1) << 25);
    return v[24:0];
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] a, bit m);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef JTFRAME_POCKET_UPLOAD_BSWAP_EN
      w = w | (32'(mem_byte(byte_addr(a, k), m)) << (8 * (3 - k)));
`else
      w = w | (32'(mem_byte(byte_addr(a, k), m)) << (8 * k));
`endif
    end
    return w;
  endfunction

  function automatic logic [31:0] swap_le(logic [31:0] w);
`ifdef JTFRAME_POCKET_UPLOAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Core memory: ioctl_din reflects the address presented exactly DIN_LAT cycles earlier.
  logic [24:0] pipe [3][8];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      pipe[g][0] <= ioctl_addr_v[g];
      for (int i = 1; i < 8; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end
  always_comb begin
    for (int g = 0; g < 3; g++) din_v[g] = mem_byte(pipe[g][lat_of(g)-1], mem_mode);
  end

  task automatic check(string nm, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Scoreboard: every ioctl_rd and rd_done must match the next queued expectation.
  always @(negedge clk) begin
    logic [26:0] ea;
    logic [33:0] ew;
    int          et;
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (ioctl_rd_v[g]) begin
          if (addr_q.size() == 0) check("ioctl_rd_unexpected", 64'(ioctl_addr_v[g]), 64'h1_0000_0000);
          else begin
            ea = addr_q.pop_front();
            check("ioctl_addr", 64'({2'(g), ioctl_addr_v[g]}), 64'(ea));
          end
        end
        if (rd_done_v[g]) begin
          if (exp_q.size() == 0) check("rd_done_unexpected", 64'(rd_data_v[g]), 64'h1_0000_0000);
          else begin
            ew = exp_q.pop_front();
            et = t_q.pop_front();
            check("sb_rd_data", 64'({2'(g), rd_data_v[g]}), 64'(ew));
            check("rd_done_latency", 64'(cyc - et), 64'(4 * (lat_of(g) + 1) + 1));
          end
        end
      end
    end
  end

  task automatic issue_rd(int g, logic [31:0] a, bit legal);
    @(negedge clk);
    rd_v[g]   = 1'b1;
    addr_v[g] = a;
    if (legal) begin
      exp_q.push_back({2'(g), model_word(a, mem_mode)});
      t_q.push_back(cyc);
      for (int k = 0; k < 4; k++) addr_q.push_back({2'(g), byte_addr(a, k)});
    end
    @(negedge clk);
    rd_v[g] = 1'b0;
  endtask

  task automatic wait_done(int g, int budget, output int t_done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rd_done_v[g]) seen = 1'b1;
    end
    check("rd_done_seen", 64'(seen), 64'd1);
    t_done = cyc;
  endtask

  task automatic check_zero(string nm);
    check({nm, "_rd_data"},    64'(rd_data_v[0]),    64'd0);
    check({nm, "_rd_done"},    64'(rd_done_v[0]),    64'd0);
    check({nm, "_busy"},       64'(busy_v[0]),       64'd0);
    check({nm, "_overrun"},    64'(overrun_v[0]),    64'd0);
    check({nm, "_ioctl_addr"}, 64'(ioctl_addr_v[0]), 64'd0);
    check({nm, "_ioctl_rd"},   64'(ioctl_rd_v[0]),   64'd0);
    check({nm, "_uploading"},  64'(upl_v[0]),        64'd0);
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(nm);
    exp_q.delete();
    t_q.delete();
    addr_q.delete();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [24:0] last_addr;
  } vec_t;

  vec_t tbl[5];
  int   td;
  int   prev;

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      rd_v[g] = 1'b0; addr_v[g] = 32'd0; slot_v[g] = 1'b0;
    end
    tbl[0] = '{32'h0000_0010, 32'h4342_4140, 25'h0000043};
    tbl[1] = '{32'h007F_FFFF, 32'hFFFE_FDFC, 25'h1FFFFFF};
    tbl[2] = '{32'h0080_0000, 32'h0302_0100, 25'h0000003};
    tbl[3] = '{32'h0001_2345, 32'h1716_1514, 25'h0048D17};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFE_FDFC, 25'h1FFFFFF};

    do_reset("reset");

    // Directed words, memory byte n = n[7:0]
    for (int i = 0; i < 5; i++) begin
      issue_rd(0, tbl[i].addr, 1'b1);
      check("busy_c1", 64'(busy_v[0]), 64'd1);
      check("uploading_c1", 64'(upl_v[0]), 64'd1);
      wait_done(0, 40, td);
      check("tbl_rd_data", 64'(rd_data_v[0]), 64'(swap_le(tbl[i].word)));
      check("tbl_last_addr", 64'(ioctl_addr_v[0]), 64'(tbl[i].last_addr));
      check("tbl_busy_done", 64'(busy_v[0]), 64'd1);
      @(negedge clk);
      check("tbl_busy_idle", 64'(busy_v[0]), 64'd0);
      check("tbl_rd_done_pulse", 64'(rd_done_v[0]), 64'd0);
    end

    // rd during a fetch is dropped and flagged
    do_reset("reset_ovr");
    issue_rd(0, 32'h20, 1'b1);
    check("overrun_before", 64'(overrun_v[0]), 64'd0);
    repeat (3) @(negedge clk);
    issue_rd(0, 32'h55, 1'b0);
    check("overrun_set", 64'(overrun_v[0]), 64'd1);
    wait_done(0, 40, td);
    check("ovr_rd_data", 64'(rd_data_v[0]), 64'(swap_le(32'h8382_8180)));
    repeat (20) @(negedge clk);
    check("overrun_sticky", 64'(overrun_v[0]), 64'd1);

    // rd in the rd_done cycle is dropped and flagged
    do_reset("reset_done_rd");
    issue_rd(0, 32'h30, 1'b1);
    wait_done(0, 40, td);
    rd_v[0] = 1'b1; addr_v[0] = 32'h99;
    @(negedge clk);
    rd_v[0] = 1'b0;
    check("done_rd_overrun", 64'(overrun_v[0]), 64'd1);
    check("done_rd_idle", 64'(busy_v[0]), 64'd0);
    repeat (20) @(negedge clk);

    // Reset in the middle of a fetch
    do_reset("reset_mid_pre");
    issue_rd(0, 32'h40, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    exp_q.delete(); t_q.delete(); addr_q.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue_rd(0, 32'h41, 1'b1);
    wait_done(0, 40, td);
    check("after_rst_data", 64'(rd_data_v[0]), 64'(model_word(32'h41, mem_mode)));

    // slot_done deferred during a fetch, immediate in IDLE
    do_reset("reset_slot");
    issue_rd(0, 32'h50, 1'b1);
    repeat (3) @(negedge clk);
    slot_v[0] = 1'b1;
    @(negedge clk);
    slot_v[0] = 1'b0;
    check("slot_deferred", 64'(upl_v[0]), 64'd1);
    wait_done(0, 40, td);
    check("slot_at_done", 64'(upl_v[0]), 64'd1);
    @(negedge clk);
    check("slot_after_done", 64'(upl_v[0]), 64'd0);
    issue_rd(0, 32'h51, 1'b1);
    wait_done(0, 40, td);
    @(negedge clk);
    check("upl_idle_kept", 64'(upl_v[0]), 64'd1);
    slot_v[0] = 1'b1;
    @(negedge clk);
    slot_v[0] = 1'b0;
    check("slot_idle_clear", 64'(upl_v[0]), 64'd0);

    // Random addresses and gaps against the model
    do_reset("reset_rand");
    mem_mode = 1'b1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_rd(0, $urandom, 1'b1);
      wait_done(0, 40, td);
    end
    check("rand_overrun", 64'(overrun_v[0]), 64'd0);

    // Back-to-back sweep at DIN_LAT 1 and 7
    for (int g = 1; g < 3; g++) begin
      prev = 0;
      for (int n = 0; n < 12; n++) begin
        issue_rd(g, $urandom, 1'b1);
        wait_done(g, 100, td);
        if (n > 0) check("b2b_spacing", 64'(td - prev), 64'(4 * (lat_of(g) + 1) + 2));
        prev = td;
      end
      check("sweep_overrun", 64'(overrun_v[g]), 64'd0);
    end

    repeat (5) @(negedge clk);
    check("queues_drained", 64'(exp_q.size() + addr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
